// File: rtl/alu_defs_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs_pkg
// Shared definitions for the execute-stage ALU:
//   - 4-bit internal ALU control codes
//   - R-type funct field values
//   - ALUOp encodings coming from the main decoder
//   - multiplier FSM state encodings
// ---------------------------------------------------------------------------
package alu_defs_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_SLTU = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_MULT = 4'b1101
    } alu_ctl_e;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_MULT = 6'b011000;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_RTYPE = 2'b10,
        AOP_OR    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational ALU-control decoder: ALUOp + funct -> 4-bit ALU op.
// Optional feature macro: ALU_MULT_EN (funct 011000 decodes to MULT only
// when defined; otherwise it falls to the AND default).
// Ports:
//   alu_op_i   [1:0]  ALUOp from main control
//   funct_i    [5:0]  instruction[5:0], used only for R-type
//   op_o       [3:0]  decoded ALU operation
//   ovf_chk_o         op is signed add/sub whose overflow must be flagged
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_defs_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output alu_ctl_e   op_o,
    output logic       ovf_chk_o
);

    always_comb begin
        op_o      = OP_AND;
        ovf_chk_o = 1'b0;
        case (alu_op_i)
            AOP_ADD: op_o = OP_ADD;
            AOP_SUB: op_o = OP_SUB;
            AOP_OR:  op_o = OP_OR;
            default: begin
                case (funct_i)
                    FN_ADD:  begin op_o = OP_ADD; ovf_chk_o = 1'b1; end
                    FN_ADDU: op_o = OP_ADD;
                    FN_SUB:  begin op_o = OP_SUB; ovf_chk_o = 1'b1; end
                    FN_SUBU: op_o = OP_SUB;
                    FN_AND:  op_o = OP_AND;
                    FN_OR:   op_o = OP_OR;
                    FN_XOR:  op_o = OP_XOR;
                    FN_NOR:  op_o = OP_NOR;
                    FN_SLT:  op_o = OP_SLT;
                    FN_SLTU: op_o = OP_SLTU;
                    FN_SLL:  op_o = OP_SLL;
                    FN_SRL:  op_o = OP_SRL;
                    FN_SRA:  op_o = OP_SRA;
`ifdef ALU_MULT_EN
                    FN_MULT: op_o = OP_MULT;
`endif
                    default: op_o = OP_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Registered MIPS execute-stage ALU with optional iterative signed multiply.
// Optional feature macro: ALU_MULT_EN (multiplier FSM, HI/LO, out_hi).
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   in_valid / in_ready     input handshake (ready low only while multiplying)
//   alu_op, funct, shamt    control inputs
//   src_a, src_b            operands
//   out_valid               one-cycle pulse, result registers valid
//   out_result / out_hi     result (LO for mult) / HI word (0 otherwise)
//   out_zero, out_overflow  result==0, signed add/sub overflow
// ---------------------------------------------------------------------------
module alu_exec_stage
    import alu_defs_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_result,
    output logic [DATA_W-1:0]  out_hi,
    output logic               out_zero,
    output logic               out_overflow
);

    localparam int unsigned M = DATA_W - 1;

    alu_ctl_e          op;
    logic              ovf_chk;
    logic              accept;
    logic [DATA_W-1:0] sum, diff, alu_res;
    logic              alu_ovf;
    logic [CNT_W-1:0]  sh_amt;

    logic              valid_q, zero_q, ovf_q;
    logic [DATA_W-1:0] result_q;

    alu_op_decode u_dec (
        .alu_op_i  (alu_op),
        .funct_i   (funct),
        .op_o      (op),
        .ovf_chk_o (ovf_chk)
    );

    assign accept = in_valid && in_ready;
    assign sum    = src_a + src_b;
    assign diff   = src_a - src_b;
    assign sh_amt = CNT_W'(shamt);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = ovf_chk && (src_a[M] == src_b[M]) && (sum[M] != src_a[M]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = ovf_chk && (src_a[M] != src_b[M]) && (diff[M] != src_a[M]);
            end
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            OP_SLL:  alu_res = src_b << sh_amt;
            OP_SRL:  alu_res = src_b >> sh_amt;
            OP_SRA:  alu_res = $signed(src_b) >>> sh_amt;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULT_EN
    mul_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_q;
    logic [DATA_W-1:0]   mcand_q, hi_q;
    logic [2*DATA_W-1:0] hilo_q;
    logic [DATA_W-1:0]   mag_a, mag_b, addend;
    logic [DATA_W:0]     step_sum;
    logic [2*DATA_W-1:0] step_next, prod_fin;
    logic                is_mult, last_step;

    assign is_mult   = (op == OP_MULT);
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));
    // Magnitudes are unsigned, so the most-negative operand maps to 2^(W-1).
    assign mag_a     = src_a[M] ? ('0 - src_a) : src_a;
    assign mag_b     = src_b[M] ? ('0 - src_b) : src_b;

    // HI accumulates the multiplicand, then {carry,HI,LO} shifts right;
    // the multiplier is consumed from LO's LSB as product bits enter at the top.
    assign addend    = hilo_q[0] ? mcand_q : '0;
    assign step_sum  = {1'b0, hilo_q[2*DATA_W-1:DATA_W]} + {1'b0, addend};
    assign step_next = {step_sum, hilo_q[DATA_W-1:1]};
    assign prod_fin  = sign_q ? ('0 - step_next) : step_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = (accept && is_mult) ? ST_MUL : ST_IDLE;
            ST_MUL:           if (last_step) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q != ST_MUL);
    end

    // Final product is registered on the last MUL step so out_valid shows
    // during DONE, giving DATA_W+1 cycles from accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            hilo_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                if (is_mult) begin
                    mcand_q <= mag_a;
                    hilo_q  <= {{DATA_W{1'b0}}, mag_b};
                    sign_q  <= src_a[M] ^ src_b[M];
                    cnt_q   <= '0;
                end else begin
                    valid_q  <= 1'b1;
                    result_q <= alu_res;
                    hi_q     <= '0;
                    zero_q   <= (alu_res == '0);
                    ovf_q    <= alu_ovf;
                end
            end else if (state_q == ST_MUL) begin
                hilo_q <= step_next;
                cnt_q  <= cnt_q + 1'b1;
                if (last_step) begin
                    valid_q  <= 1'b1;
                    hi_q     <= prod_fin[2*DATA_W-1:DATA_W];
                    result_q <= prod_fin[DATA_W-1:0];
                    zero_q   <= (prod_fin[DATA_W-1:0] == '0);
                    ovf_q    <= 1'b0;
                end
            end
        end
    end

    assign out_hi = hi_q;
`else
    assign in_ready = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                ovf_q    <= alu_ovf;
            end
        end
    end

    assign out_hi = '0;
`endif

    assign out_valid    = valid_q;
    assign out_result   = result_q;
    assign out_zero     = zero_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed self-checking bench for alu_exec_stage. Multiplier tests are
// compiled when ALU_MULT_EN is defined; otherwise the MULT funct is checked
// to behave as AND with latency 1.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] out_result, out_hi;
    logic        out_zero, out_overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    alu_exec_stage #(.DATA_W(32), .SHAMT_W(5), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .funct        (funct),
        .src_a        (src_a),
        .src_b        (src_b),
        .shamt        (shamt),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_hi       (out_hi),
        .out_zero     (out_zero),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aop, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        alu_op = aop; funct = fn; src_a = a; src_b = b; shamt = sh;
    endtask

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_res, input logic exp_zero, input logic exp_ovf);
        drive(aop, fn, a, b, sh);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".res"},   64'(out_result), 64'(exp_res));
        check_eq({tag, ".zero"},  64'(out_zero), 64'(exp_zero));
        check_eq({tag, ".ovf"},   64'(out_overflow), 64'(exp_ovf));
        check_eq({tag, ".hi"},    64'(out_hi), 64'd0);
    endtask

`ifdef ALU_MULT_EN
    // Accept a MULT and wait (bounded) for its result; reports busy cycles.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_zero);
        int unsigned busy;
        int unsigned waited;
        drive(2'b10, 6'b011000, a, b, 5'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        busy = 0;
        waited = 0;
        while (!out_valid && waited < 40) begin
            if (!in_ready) busy++;
            tick();
            waited++;
        end
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".busy"},  64'(busy), 64'd32);
        check_eq({tag, ".hi"},    64'(out_hi), 64'(exp_hi));
        check_eq({tag, ".lo"},    64'(out_result), 64'(exp_lo));
        check_eq({tag, ".zero"},  64'(out_zero), 64'(exp_zero));
        check_eq({tag, ".rdy"},   64'(in_ready), 64'd1);
    endtask
`endif

    logic [1:0]  bb_aop [4];
    logic [5:0]  bb_fn  [4];
    logic [31:0] bb_a   [4];
    logic [31:0] bb_b   [4];
    logic [31:0] bb_exp [4];

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        drive(2'b00, 6'b0, 32'd0, 32'd0, 5'd0);
        tick();
        tick();
        check_eq("rst.valid", 64'(out_valid), 64'd0);
        check_eq("rst.res",   64'(out_result), 64'd0);
        check_eq("rst.hi",    64'(out_hi), 64'd0);
        check_eq("rst.zero",  64'(out_zero), 64'd0);
        check_eq("rst.ovf",   64'(out_overflow), 64'd0);
        check_eq("rst.rdy",   64'(in_ready), 64'd1);
        reset = 1'b0;
        tick();
        check_eq("idle.valid", 64'(out_valid), 64'd0);

        run_op("add",   2'b00, 6'b0,      32'd5,        32'd7,        5'd0, 32'd12,       1'b0, 1'b0);
        run_op("beq",   2'b01, 6'b0,      32'h1234,     32'h1234,     5'd0, 32'd0,        1'b1, 1'b0);
        run_op("addov", 2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1,        5'd0, 32'h80000000, 1'b0, 1'b1);
        run_op("addu",  2'b10, 6'b100001, 32'h7FFFFFFF, 32'd1,        5'd0, 32'h80000000, 1'b0, 1'b0);
        run_op("subov", 2'b10, 6'b100010, 32'h80000000, 32'd1,        5'd0, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_op("subu",  2'b10, 6'b100011, 32'h80000000, 32'd1,        5'd0, 32'h7FFFFFFF, 1'b0, 1'b0);
        run_op("sra",   2'b10, 6'b000011, 32'h0,        32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0);
        run_op("srl",   2'b10, 6'b000010, 32'h0,        32'h80000000, 5'd4, 32'h08000000, 1'b0, 1'b0);
        run_op("sll",   2'b10, 6'b000000, 32'h0,        32'h80000000, 5'd4, 32'h0,        1'b1, 1'b0);
        run_op("unk",   2'b10, 6'b111111, 32'hF0,       32'h3C,       5'd0, 32'h30,       1'b0, 1'b0);
        run_op("slt",   2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        1'b0, 1'b0);
        run_op("sltu",  2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,        1'b1, 1'b0);
        run_op("nor",   2'b10, 6'b100111, 32'h0,        32'h0,        5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("ori",   2'b11, 6'b0,      32'hF0,       32'h0F,       5'd0, 32'hFF,       1'b0, 1'b0);
        run_op("xor",   2'b10, 6'b100110, 32'hFF,       32'h0F,       5'd0, 32'hF0,       1'b0, 1'b0);
        run_op("and",   2'b10, 6'b100100, 32'hF0F0,     32'hFF00,     5'd0, 32'hF000,     1'b0, 1'b0);

        // Back-to-back: one accept per cycle, results appear in order.
        bb_aop = '{2'b00, 2'b01, 2'b11, 2'b10};
        bb_fn  = '{6'b0, 6'b0, 6'b0, 6'b100110};
        bb_a   = '{32'd1, 32'd10, 32'hA, 32'hFF};
        bb_b   = '{32'd1, 32'd3, 32'h5, 32'h0F};
        bb_exp = '{32'd2, 32'd7, 32'hF, 32'hF0};
        for (int i = 0; i < 4; i++) begin
            drive(bb_aop[i], bb_fn[i], bb_a[i], bb_b[i], 5'd0);
            in_valid = 1'b1;
            tick();
            check_eq($sformatf("b2b%0d.valid", i), 64'(out_valid), 64'd1);
            check_eq($sformatf("b2b%0d.res", i), 64'(out_result), 64'(bb_exp[i]));
        end
        in_valid = 1'b0;
        drive(2'b00, 6'b0, 32'd100, 32'd100, 5'd0);
        tick();
        check_eq("hold.valid", 64'(out_valid), 64'd0);
        check_eq("hold.res",   64'(out_result), 64'hF0);

`ifdef ALU_MULT_EN
        // -3 * 7 with a new op held on in_valid throughout the multiply.
        begin
            int unsigned busy;
            int unsigned early;
            drive(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7, 5'd0);
            in_valid = 1'b1;
            tick();
            drive(2'b00, 6'b0, 32'd2, 32'd3, 5'd0);
            busy = 0;
            early = 0;
            for (int k = 1; k <= 32; k++) begin
                if (!in_ready) busy++;
                if (out_valid) early++;
                tick();
            end
            check_eq("m1.busy",  64'(busy), 64'd32);
            check_eq("m1.early", 64'(early), 64'd0);
            check_eq("m1.valid", 64'(out_valid), 64'd1);
            check_eq("m1.hi",    64'(out_hi), 64'hFFFFFFFF);
            check_eq("m1.lo",    64'(out_result), 64'hFFFFFFEB);
            check_eq("m1.rdy",   64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            check_eq("held.valid", 64'(out_valid), 64'd1);
            check_eq("held.res",   64'(out_result), 64'd5);
            check_eq("held.hi",    64'(out_hi), 64'd0);
            tick();
            check_eq("held.once",  64'(out_valid), 64'd0);
        end

        run_mult("mneg", 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h0, 1'b1);
        run_mult("mnn",  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b1);
        run_mult("mpos", 32'd12345,    32'd1000,     32'h0,        32'd12345000, 1'b0);

        // Reset in the middle of a multiply aborts it.
        begin
            int unsigned stray;
            drive(2'b10, 6'b011000, 32'd9, 32'd9, 5'd0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 9; k++) tick();
            check_eq("ab.busy", 64'(in_ready), 64'd0);
            reset = 1'b1;
            #1;
            check_eq("ab.rdy",   64'(in_ready), 64'd1);
            check_eq("ab.valid", 64'(out_valid), 64'd0);
            check_eq("ab.res",   64'(out_result), 64'd0);
            check_eq("ab.hi",    64'(out_hi), 64'd0);
            check_eq("ab.zero",  64'(out_zero), 64'd0);
            tick();
            reset = 1'b0;
            stray = 0;
            for (int k = 0; k < 40; k++) begin
                if (out_valid) stray++;
                tick();
            end
            check_eq("ab.stray", 64'(stray), 64'd0);
            run_op("ab.add", 2'b00, 6'b0, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0, 1'b0);
        end
`else
        run_op("multoff", 2'b10, 6'b011000, 32'hF0, 32'h3C, 5'd0, 32'h30, 1'b0, 1'b0);
        check_eq("multoff.rdy", 64'(in_ready), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Parametrised, registered execute-stage ALU for the MIPS pipeline. It merges ALU-control decoding (ALUOp + funct) with the datapath. Single-cycle ops produce a registered result one cycle after acceptance. An optional iterative signed multiplier stalls the stage through a valid/ready handshake. It sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
DATA_W, 32, operand/result width (≥8, power of 2)
SHAMT_W, 5, shift-amount width; must equal log2(DATA_W)
CNT_W, 6, multiplier iteration counter width; must hold DATA_W

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operands/controls present this cycle
in_ready  out  1  stage can accept (low only while multiplying)
alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type via funct, 11 OR (ori)
funct  in  6  instruction[5:0]; used only when alu_op=10
src_a  in  DATA_W  rs operand
src_b  in  DATA_W  rt / sign-extended immediate
shamt  in  SHAMT_W  shift amount for sll/srl/sra
out_valid  out  1  one-cycle pulse: result registers valid
out_result  out  DATA_W  result (LO for mult)
out_hi  out  DATA_W  HI word of mult; 0 otherwise
out_zero  out  1  out_result == 0
out_overflow  out  1  signed overflow on add/sub funct

Behaviour:
- Reset: all outputs 0; in_ready 1; FSM to IDLE; HI/LO and counter cleared. Asserting reset mid-multiply aborts it; no out_valid is produced for the aborted op.
- 4-bit op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
  - 0011 XOR, 1100 NOR, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLTU, 1101 MULT
- alu_op decode: 00→ADD, 01→SUB, 11→OR, 10→funct.
- funct decode:
  - 100000/100001→ADD, 100010/100011→SUB
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA, 011000 MULT
  - any other funct→AND
- Shifts operate on src_b by shamt. SRA sign-fills.
- SLT is signed compare; SLTU is unsigned. Result is 1 or 0, zero-extended.
- out_overflow: set only for funct 100000/100010 on signed overflow. The result is still written; the flag is 0 for all other ops.
- Accept condition: in_valid && in_ready.
- Single-cycle ops: registered; out_valid=1 in the cycle after acceptance (latency 1). Back-to-back every cycle is supported. out_valid is 0 with no accept; out_result holds its last value.
- Multiply FSM:
  - IDLE→MUL on accepted MULT. Latch |a|, |b| and sign = a[MSB]^b[MSB]. in_ready=0.
  - MUL: one shift-add step per cycle for DATA_W cycles; counter counts 0..DATA_W-1.
  - DONE: apply two's-complement negation of the 2·DATA_W product if sign=1. Load out_hi/out_result; out_valid=1; in_ready=1; next state IDLE.
  - Total latency DATA_W+1 cycles from accept to out_valid.
  - in_valid while in_ready=0 is not accepted; the upstream holds it.
- Most-negative operand (0x80000000) multiplies correctly; magnitude is treated as unsigned.
- out_zero reflects out_result (LO) for mult.

Optional Feature:
ALU_MULT_EN.
- Defined: MULT FSM, HI/LO and out_hi are implemented as above.
- Undefined: funct 011000 decodes to the default (AND); in_ready is tied 1; out_hi is tied 0; no FSM is built; all ops have latency 1.

Decomposition:
- Shared include/package alu_defs holds:
  - 4-bit op-code constants
  - funct constants
  - alu_op encodings
  - FSM state encodings IDLE/MUL/DONE
- One natural sub-module, alu_op_decode: combinational alu_op+funct→4-bit op. The top holds the datapath, output registers and multiplier FSM.

Test Plan:
1. alu_op=00, a=5, b=7 → next cycle out_valid=1, result=12, zero=0, overflow=0.
2. alu_op=01, a=b=0x1234 → result=0, zero=1. Then funct 100000, a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1.
3. Shifts with b=0x80000000, shamt=4: SRA→0xF8000000, SRL→0x08000000, SLL→0. Unknown funct 111111 with a=0xF0, b=0x3C → 0x30 (AND).
4. a=0xFFFFFFFF, b=1: SLT→1, SLTU→0. NOR with a=b=0 → 0xFFFFFFFF. Back-to-back 4 ops → 4 consecutive out_valid pulses, in order.
5. ALU_MULT_EN, a=-3, b=7 → in_ready low 32 cycles; out_valid at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB. in_valid held high meanwhile is accepted only once in_ready returns.
6. ALU_MULT_EN, MULT accepted then reset pulsed at cycle 10 → immediately busy cleared, in_ready=1, all outputs 0, no out_valid. Next ADD 2+2 → 4 after 1 cycle.
